vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator with run/stop control and a sync
//  delay line. Drives the monitor sync pins and feeds (column, line) to the
//  pixel-fetch path of the debug display. Sync/de are delayed to align with
//  the downstream pixel pipeline latency.
// PARAMETERS
//  H_ACTIVE   1280  visible pixels per line
//  H_FP       48    horizontal front porch, clocks
//  H_SYNC     112   hsync pulse width, clocks
//  H_BP       248   horizontal back porch, clocks (H_TOTAL=1688)
//  V_ACTIVE   1024  visible lines per frame
//  V_FP       1     vertical front porch, lines
//  V_SYNC     3     vsync pulse width, lines
//  V_BP       38    vertical back porch, lines (V_TOTAL=1066)
//  HSYNC_POL  1'b0  asserted hsync level (0 = active-low)
//  VSYNC_POL  1'b0  asserted vsync level
//  PIPE_DELAY 2     sync/de delay in clocks, 0..7
// PORTS
//  clk108mhz    in   1   pixel clock
//  reset        in   1   synchronous, active-low
//  run          in   1   1 = generate frames; 0 = stop at end of current frame
//  hsync        out  1   horizontal sync, delayed PIPE_DELAY
//  vsync        out  1   vertical sync, delayed PIPE_DELAY
//  de           out  1   display enable (active area), delayed PIPE_DELAY
//  column       out  12  current X, undelayed
//  line         out  12  current Y, undelayed
//  line_start   out  1   1-clk pulse when column==0 (RUN/DRAIN only), undelayed
//  frame_start  out  1   1-clk pulse when column==0 && line==0, undelayed
//  busy         out  1   1 in RUN or DRAIN
// BEHAVIOUR
//  - Reset: reset is synchronous, active-low; clock is clk108mhz. While
//    reset==0: state=IDLE, column=0, line=0, hsync=~HSYNC_POL,
//    vsync=~VSYNC_POL, de=0, pulses=0, busy=0; delay line flushed to the same
//    inactive values. Reset mid-frame aborts immediately, no drain.
//  - FSM: IDLE -> RUN when run==1 (first RUN clk has column=0, line=0,
//    frame_start=1). RUN -> DRAIN when run==0. DRAIN -> RUN when run==1
//    again (no glitch, counters continue). DRAIN -> IDLE on the clock after
//    column==H_TOTAL-1 && line==V_TOTAL-1. IDLE holds counters at 0.
//  - Counters: column 0..H_TOTAL-1, wraps to 0 and increments line; line
//    0..V_TOTAL-1, wraps to 0. Both are registered outputs, no 12-bit overflow
//    (H_TOTAL, V_TOTAL <= 4096, checked at elaboration).
//  - Raw decode (same clock as counters): hs_raw asserted for column in
//    [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs_raw asserted for line in
//    [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) for the whole line;
//    de_raw = column<H_ACTIVE && line<V_ACTIVE. All inactive in IDLE.
//  - Outputs hsync/vsync/de = raw decode delayed by exactly PIPE_DELAY clks
//    (PIPE_DELAY=0: combinational from counter registers). Polarity applied
//    before the delay line.
//  - IDLE->RUN and DRAIN->IDLE transitions appear on sync pins PIPE_DELAY
//    clks after the counter-side event; busy is undelayed.
// CONFIGURATION
//  VGA_TIMING_FRAME_COUNT_EN defined: extra port frame_count out 16 bits,
//    reset 0, increments on each frame_start pulse, wraps 65535->0, holds in
//    IDLE. Not defined: port absent, no counter logic.
// TESTING
//  1 reset=0 3 clks, run=1 -> hsync=vsync=1, de=0, column=line=0, busy=0.
//  2 reset=1,run=1 -> next clk frame_start=1; de=1 at clk PIPE_DELAY(2)
//    after; hsync low for column 1328..1439 (seen 2 clks later), 112 clks.
//  3 Full frame -> vsync low exactly lines 1025..1027 (3*1688 clks); period
//    1688*1066=1799408 clks between frame_start pulses.
//  4 run=0 at line 500 -> frame completes; DRAIN->IDLE after (1687,1065);
//    run=1 at line 700 in DRAIN -> no stop, next frame_start at normal period.
//  5 reset=0 at column 800, line 300 -> next clk all outputs at reset values.
//  6 Params H=4+1+2+1, V=3+1+1+1, PIPE_DELAY=0, POL=1 -> hsync high column
//    5..6, vsync high line 4, frame period 48 clks; with
//    VGA_TIMING_FRAME_COUNT_EN frame_count=3 after 3 frame_starts.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: column/line counters, run/stop control and a sync/de delay line.
// Define VGA_TIMING_FRAME_COUNT_EN to add the 16-bit frame_count output.
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 1280,
    parameter int   H_FP       = 48,
    parameter int   H_SYNC     = 112,
    parameter int   H_BP       = 248,
    parameter int   V_ACTIVE   = 1024,
    parameter int   V_FP       = 1,
    parameter int   V_SYNC     = 3,
    parameter int   V_BP       = 38,
    parameter logic HSYNC_POL  = 1'b0,
    parameter logic VSYNC_POL  = 1'b0,
    parameter int   PIPE_DELAY = 2
) (
    input  logic        clk108mhz,
    input  logic        reset,
    input  logic        run,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] column,
    output logic [11:0] line,
    output logic        line_start,
    output logic        frame_start,
`ifdef VGA_TIMING_FRAME_COUNT_EN
    output logic        busy,
    output logic [15:0] frame_count
`else
    output logic        busy
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Decode bounds are 13 bits wide so a sync window ending exactly at 4096 cannot alias to 0.
    localparam logic [12:0] H_LAST   = 13'(H_TOTAL - 1);
    localparam logic [12:0] V_LAST   = 13'(V_TOTAL - 1);
    localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [2:0] SYNC_IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be in 0..7");
    end

    logic [1:0]  state_q, state_d;
    logic [11:0] column_q, column_d;
    logic [11:0] line_q, line_d;
    logic [12:0] col_x, line_x;
    logic        active, end_of_line, end_of_frame;

    assign col_x        = {1'b0, column_q};
    assign line_x       = {1'b0, line_q};
    assign active       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign end_of_line  = (col_x == H_LAST);
    assign end_of_frame = end_of_line && (line_x == V_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_RUN;
            // Dropping run on the very last pixel has no frame left to drain, so stop straight away.
            ST_RUN:   if (!run) state_d = end_of_frame ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (run) state_d = ST_RUN;
                else if (end_of_frame) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        column_d = '0;
        line_d   = '0;
        if (active && !end_of_frame) begin
            if (end_of_line) begin
                line_d = line_q + 12'd1;
            end else begin
                column_d = column_q + 12'd1;
                line_d   = line_q;
            end
        end
    end

    always_ff @(posedge clk108mhz) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            column_q <= '0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            column_q <= column_d;
            line_q   <= line_d;
        end
    end

    logic       hs_raw, vs_raw, de_raw;
    logic [2:0] sync_raw, sync_out;

    assign hs_raw   = active && (col_x >= HS_START) && (col_x < HS_END);
    assign vs_raw   = active && (line_x >= VS_START) && (line_x < VS_END);
    assign de_raw   = active && (col_x < H_ACT) && (line_x < V_ACT);
    assign sync_raw = {hs_raw ? HSYNC_POL : ~HSYNC_POL,
                       vs_raw ? VSYNC_POL : ~VSYNC_POL,
                       de_raw};

    if (PIPE_DELAY == 0) begin : g_no_pipe
        assign sync_out = sync_raw;
    end else begin : g_pipe
        logic [2:0] pipe_q [PIPE_DELAY];
        logic [2:0] pipe_d [PIPE_DELAY];

        always_comb begin
            pipe_d[0] = sync_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        always_ff @(posedge clk108mhz) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                if (!reset) pipe_q[i] <= SYNC_IDLE;
                else        pipe_q[i] <= pipe_d[i];
            end
        end

        assign sync_out = pipe_q[PIPE_DELAY-1];
    end

    assign {hsync, vsync, de} = sync_out;
    assign column      = column_q;
    assign line        = line_q;
    assign line_start  = active && (column_q == 12'd0);
    assign frame_start = line_start && (line_q == 12'd0);
    assign busy        = active;

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (frame_start) frame_count_d = frame_count_q + 16'd1;
    end

    always_ff @(posedge clk108mhz) begin
        if (!reset) frame_count_q <= '0;
        else        frame_count_q <= frame_count_d;
    end

    assign frame_count = frame_count_q;
`endif

endmodule
